// File: rtl/pt_feeder_pkg.sv
// pt_pkg: shared widths, phase encoding and chunk selection for the point feeder
package pt_pkg;
  localparam int COORD_W       = 10;
  localparam int CHUNK_W       = 5;
  localparam int CHUNKS_PER_PT = 4;
  localparam int PT_CNT_W      = 12;
  localparam int PT_W          = 2 * COORD_W;
  localparam logic [PT_CNT_W-1:0] PT_CNT_MAX = '1;
  typedef enum logic [1:0] {
    P_XH = 2'd0,
    P_XL = 2'd1,
    P_YH = 2'd2,
    P_YL = 2'd3
  } phase_e;
  function automatic logic [CHUNK_W-1:0] chunk_of(input logic [PT_W-1:0] pt, input phase_e ph);
    return pt[PT_W-1-CHUNK_W*int'(ph) -: CHUNK_W];
  endfunction
endpackage

// File: rtl/pt_feeder_if.sv
// pt_feeder_if: producer handshake, engine chunk bus and status of the point feeder
interface pt_feeder_if import pt_pkg::*; #(parameter int AW = 4);
  logic [COORD_W-1:0]  IN_X;
  logic [COORD_W-1:0]  IN_Y;
  logic                IN_VALID;
  logic                IN_READY;
  logic                READ_PT;
  logic [CHUNK_W-1:0]  PT_XY;
  logic [AW:0]         FIFO_CNT;
  logic [PT_CNT_W-1:0] PT_CNT;
  logic                UNDERFLOW;
  modport master (
    output IN_X, IN_Y, IN_VALID, READ_PT,
    input  IN_READY, PT_XY, FIFO_CNT, PT_CNT, UNDERFLOW
  );
  modport slave (
    input  IN_X, IN_Y, IN_VALID, READ_PT,
    output IN_READY, PT_XY, FIFO_CNT, PT_CNT, UNDERFLOW
  );
endinterface

// File: rtl/pt_fifo.sv
// pt_fifo: synchronous FIFO with occupancy count; push ignored when full, pop ignored when empty
module pt_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   cnt_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign cnt_o   = cnt_q;
  assign dout_o  = mem_q[rp_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  // pointer and occupancy next state; pointers wrap naturally at DEPTH
  always_comb begin
    wp_d  = wp_q + AW'(do_push);
    rp_d  = rp_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  // storage array, no reset needed since reads are gated by occupancy
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end
  // pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/pt_feeder.sv
// pt_feeder: buffers (x,y) points and serialises each as four 5-bit chunks on READ_PT requests
module pt_feeder import pt_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  pt_feeder_if.slave  bus
);
  phase_e              phase_q, phase_d;
  logic [PT_W-1:0]     hold_q, hold_d, head;
  logic [CHUNK_W-1:0]  pt_xy_q, pt_xy_d;
  logic [PT_CNT_W-1:0] pt_cnt_q, pt_cnt_d;
  logic                underflow_q, underflow_d;
  logic                full, empty, start;
  assign start         = bus.READ_PT && phase_q == P_XH;
  assign bus.IN_READY  = !full;
  assign bus.PT_XY     = pt_xy_q;
  assign bus.PT_CNT    = pt_cnt_q;
  assign bus.UNDERFLOW = underflow_q;
  pt_fifo #(.W(PT_W), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .push_i  (bus.IN_VALID),
    .pop_i   (start),
    .din_i   ({bus.IN_X, bus.IN_Y}),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .cnt_o   (bus.FIFO_CNT)
  );
  // phase advance, hold load at P_XH (zero point on underflow), chunk select and counters
  always_comb begin
    phase_d     = bus.READ_PT ? phase_e'(phase_q + 2'd1) : phase_q;
    hold_d      = start ? (empty ? '0 : head) : hold_q;
    pt_xy_d     = bus.READ_PT ? chunk_of(hold_d, phase_q) : pt_xy_q;
    pt_cnt_d    = (bus.READ_PT && phase_q == P_YL && pt_cnt_q != PT_CNT_MAX) ? pt_cnt_q + PT_CNT_W'(1) : pt_cnt_q;
    underflow_d = underflow_q || (start && empty);
  end
  // phase state and datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      phase_q     <= P_XH;
      hold_q      <= '0;
      pt_xy_q     <= '0;
      pt_cnt_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      pt_xy_q     <= pt_xy_d;
      pt_cnt_q    <= pt_cnt_d;
      underflow_q <= underflow_d;
    end
  end
endmodule

// File: doc/pt_feeder.md
Name: pt_feeder

Overview:
- Upstream stage for the convex-hull engine: buffers incoming 10-bit (x,y) points in a FIFO and serialises each point onto the engine's 5-bit PT_XY bus in four chunks, paced by the engine's READ_PT request.
- Decouples the point producer (valid/ready) from the engine's read cadence.
- Reports underflow and counts delivered points.

Parameters:
- DEPTH, 16, FIFO depth in points; power of two, at least 2.
- AW, 4, log2(DEPTH); FIFO pointer width.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN_X  input  10  x coordinate of the offered point.
- IN_Y  input  10  y coordinate of the offered point.
- IN_VALID  input  1  producer offers IN_X/IN_Y this cycle.
- IN_READY  output  1  FIFO can accept; a push happens when IN_VALID && IN_READY at the edge.
- READ_PT  input  1  chunk request from the engine, sampled at each rising edge.
- PT_XY  output  5  registered chunk to the engine.
- FIFO_CNT  output  AW+1  current FIFO occupancy.
- PT_CNT  output  12  points delivered since reset; saturates at 4095.
- UNDERFLOW  output  1  sticky; set when a point is requested while the FIFO is empty.

Behaviour:
- Reset: asynchronous on RST_N low. Values: PT_XY=0, phase=0, FIFO empty, FIFO_CNT=0, PT_CNT=0, UNDERFLOW=0, IN_READY=1 after reset releases. Reset mid-point discards the partial point and all buffered points.
- Phase counter (2 bits, P0..P3) advances on every edge where READ_PT=1; P3 wraps to P0. The phase does not move when READ_PT=0, and PT_XY holds its value.
- Edge with READ_PT=1 at P0:
  - Pops the FIFO head into a 20-bit hold register. If the FIFO is empty, (0,0) is loaded instead and UNDERFLOW is set.
  - PT_XY <= X[9:5].
- P1 edge: PT_XY <= X[4:0].
- P2 edge: PT_XY <= Y[9:5].
- P3 edge: PT_XY <= Y[4:0]; PT_CNT increments by 1, saturating at 4095.
- Engine timing:
  - The engine raises READ_PT one cycle before its first sample and samples PT_XY on four consecutive edges.
  - The chunk updated at request edge k is therefore stable through sample edge k+1.
  - Latency from READ_PT rise to the first valid chunk is one cycle.
- Back-to-back points are legal: READ_PT held high for 8 edges delivers two points with no bubble.
- FIFO:
  - Write on IN_VALID && IN_READY.
  - IN_READY = (FIFO_CNT != DEPTH). It is derived from registered occupancy only; there is no combinational path from READ_PT.
  - Push and pop on the same edge are always allowed, including when full (the pop frees a slot but IN_READY was already 0 that cycle, so no push occurs) and when empty (no bypass; the pop sees empty and the underflow rule applies).
  - Pointers wrap modulo DEPTH.
- UNDERFLOW clears only on reset.
- PT_XY carries unsigned 5-bit slices. The engine zero-extends each x/y to 11 bits.

Decomposition:
- Shared package pt_pkg holds:
  - COORD_W=10, CHUNK_W=5, CHUNKS_PER_PT=4.
  - Phase encoding: P_XH=0, P_XL=1, P_YH=2, P_YL=3.
  - PT_CNT_W=12.
- One sub-module: pt_fifo, a synchronous FIFO, width 20, depth DEPTH. It has push, pop, full and empty flags plus a count output, and uses the same asynchronous active-low reset.
- Phase sequencing, the hold register and the counters live in pt_feeder.

Test Plan:
- Single point: push (x=0x2A5, y=0x13C); then READ_PT high 4 cycles, low after. Expect PT_XY = 0x15, 0x05, 0x09, 0x1C on the four edges following each request edge, PT_CNT=1, FIFO_CNT=0.
- Back-to-back: push (1,2) and (1023,1023); READ_PT high for 8 cycles. Expect chunks 0x00, 0x01, 0x00, 0x02, 0x1F, 0x1F, 0x1F, 0x1F, PT_CNT=2, UNDERFLOW=0.
- Full FIFO: hold IN_VALID high with no reads. Expect IN_READY to drop after exactly 16 pushes with FIFO_CNT=16. One P0 request then yields IN_READY=1 on the next cycle, and the 17th point is accepted afterwards in order.
- Underflow: with the FIFO empty, pulse READ_PT 4 cycles. Expect PT_XY = 0 for all chunks, UNDERFLOW=1 (sticky), PT_CNT=1. A later point pushed and read arrives intact.
- Stall mid-point: READ_PT high 2 edges, low 5 cycles, high 2 edges. Expect PT_XY to hold X[4:0] during the gap, then Y chunks; phase returns to P0.
- Asynchronous reset at P2 with 3 points buffered. Expect outputs to clear immediately without waiting for a clock, FIFO_CNT=0, and the next read to start at P0 from newly pushed data.
